text_line_streamer: RTL
=======================

Name: text_line_streamer

Overview:
- Parametrised successor to the fixed character ROM / line-table pair used on the display path.
- Accepts a line index, looks up the line's word range in an external line table, and fetches packed character words from an external character memory.
- Unpacks each word into bytes and streams them over a valid/ready interface.
- Output length is a fixed LINE_LEN characters: short lines are padded, long lines are truncated, and empty or illegal ranges are reported.

Parameters:
- ADDR_W, 8, character-memory word address width.
- WORD_BYTES, 2, characters packed per memory word (data width = 8*WORD_BYTES).
- LINE_W, 8, line index width.
- LINE_LEN, 16, characters emitted per line (1..255).
- PAD_CHAR, 8'h20, fill character (ASCII space).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request pulse; sampled only when busy=0.
- line_sel  in  LINE_W  line to stream, captured with start.
- busy  out  1  high from the accepted start until the handshake of the last character.
- err  out  1  sticky range error for the current/last line; cleared on the next accepted start.
- tbl_line  out  LINE_W  registered index to the line table.
- tbl_start  in  ADDR_W  first word address, valid 1 cycle after tbl_line.
- tbl_end  in  ADDR_W  last word address (inclusive), valid 1 cycle after tbl_line.
- mem_addr  out  ADDR_W  registered character-memory address.
- mem_data  in  8*WORD_BYTES  word data, valid 1 cycle after mem_addr.
- char_data  out  8  streamed character.
- char_valid  out  1  char_data valid.
- char_ready  in  1  downstream accept.
- char_last  out  1  high with the LINE_LEN-th character.

Behaviour:
- Reset values: busy=0, err=0, tbl_line=0, mem_addr=0, char_data=PAD_CHAR, char_valid=0, char_last=0; FSM=IDLE.
- Reset asserted mid-line aborts immediately. No partial line resumes after reset.
- FSM states: IDLE, TBL, RANGE, FETCH, EMIT, PAD.
  - IDLE: on edge with start=1, go to TBL. Set tbl_line<=line_sel, busy<=1, err<=0, char count<=0.
  - TBL: wait one cycle for table data.
  - RANGE: latch tbl_start/tbl_end.
    - If tbl_start>tbl_end: err<=1, go to PAD.
    - Else mem_addr<=tbl_start, go to FETCH.
  - FETCH: wait one cycle. Capture mem_data into the byte shift register and set byte index<=0. Go to EMIT.
  - EMIT: present bytes most-significant first (bits [8*WORD_BYTES-1 -: 8] first).
    - A transfer occurs when char_valid & char_ready. Advance byte index and char count only on a transfer.
    - char_data and char_valid are held stable while char_ready=0.
    - After the last byte of a word: if mem_addr==tbl_end, go to PAD. Else mem_addr<=mem_addr+1 (wraps modulo 2^ADDR_W only if tbl_end requires it, never beyond tbl_end), go to FETCH.
  - PAD: emit PAD_CHAR with the same handshake until the char count reaches LINE_LEN.
- Count rule:
  - When the char count reaches LINE_LEN in any state, the transfer is flagged char_last=1.
  - After that transfer: busy<=0, char_valid<=0, go to IDLE. Remaining word bytes are discarded (truncation).
- Latency:
  - Accepted start at edge E0 gives first char_valid after edge E4.
  - Each new word inserts a 2-cycle bubble (FETCH plus capture) with char_valid=0. There is no prefetch.
- start while busy=1 is ignored; line_sel is not re-sampled.
- start on the same edge as the final handshake is ignored; a new start is accepted from the next IDLE cycle.
- Equal start/end addresses fetch exactly one word.
- A range error still emits a full LINE_LEN pad line with char_last, so the downstream framing is always preserved.

Test Plan:
- Table line0 = start 0x00/end 0x03; mem[0..3] = 0x3131, 0x4142, 0x7320, 0x2020; LINE_LEN=16; char_ready=1. Start line0 -> chars "11ABs   " then 8 more 0x20, char_last on the 16th char, first valid 4 cycles after start, busy low after the last transfer.
- Table line1 = 0x05/0x05, mem[5]=0x3174. Start line1 -> '1','t', then 14 pads, err=0.
- LINE_LEN=4, line0 -> exactly '1','1','A','B' with char_last on 'B'. mem_addr never advances past 0x01; FSM returns to IDLE.
- Toggle char_ready randomly (e.g. 0 for 3 cycles on every 2nd char) -> sequence identical to the first scenario, char_data stable while stalled, no dropped or duplicated bytes.
- Table returns start 0x07/end 0x02 -> err=1, 16 x 0x20 with char_last. The next start clears err.
- Assert rst for 1 cycle after the 5th char of the first scenario -> all outputs at reset values. A fresh start of line0 then reproduces the full first-scenario line from '1'.

Source files
------------

// File: rtl/text_line_streamer.sv
// text_line_streamer
//   Streams one fixed-length text line per request. A line index selects a
//   word range [tbl_start, tbl_end] from an external line table; the words
//   are fetched from an external character memory, unpacked most-significant
//   byte first, and sent over a valid/ready character stream. Lines shorter
//   than LINE_LEN are filled with PAD_CHAR, longer lines are cut at LINE_LEN,
//   and a reversed range raises err and sends a full pad line.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   start, line_sel     request pulse and line index (taken only when idle)
//   busy, err           request in progress / sticky range error
//   tbl_line            registered line-table index
//   tbl_start, tbl_end  word range from the table, one cycle after tbl_line
//   mem_addr            registered character-memory word address
//   mem_data            memory word, one cycle after mem_addr
//   char_data/valid/ready/last  character stream, last on the LINE_LEN-th char
module text_line_streamer #(
  parameter int         ADDR_W     = 8,
  parameter int         WORD_BYTES = 2,
  parameter int         LINE_W     = 8,
  parameter int         LINE_LEN   = 16,
  parameter logic [7:0] PAD_CHAR   = 8'h20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LINE_W-1:0]       line_sel,
  output logic                    busy,
  output logic                    err,
  output logic [LINE_W-1:0]       tbl_line,
  input  logic [ADDR_W-1:0]       tbl_start,
  input  logic [ADDR_W-1:0]       tbl_end,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic [8*WORD_BYTES-1:0] mem_data,
  output logic [7:0]              char_data,
  output logic                    char_valid,
  input  logic                    char_ready,
  output logic                    char_last
);

  localparam int DW   = 8*WORD_BYTES;
  localparam int BI_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [7:0]      LAST_IDX  = 8'(LINE_LEN - 1);
  localparam logic [BI_W-1:0] LAST_BYTE = BI_W'(WORD_BYTES - 1);

  typedef enum logic [2:0] {IDLE, TBL, RANGE, FETCH, EMIT, PAD} state_t;

  state_t            state;
  logic [ADDR_W-1:0] end_q;
  logic [DW-1:0]     sreg;      // remaining bytes of the current word, next at top
  logic [BI_W-1:0]   byte_idx;
  logic [7:0]        cnt;       // characters already handed over
  logic              fetch_ph;  // 0: memory read in flight, 1: capture word
  logic              xfer;
  logic [7:0]        cnt_nxt;

  assign xfer    = char_valid & char_ready;
  assign cnt_nxt = cnt + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      err        <= 1'b0;
      tbl_line   <= '0;
      mem_addr   <= '0;
      char_data  <= PAD_CHAR;
      char_valid <= 1'b0;
      char_last  <= 1'b0;
      end_q      <= '0;
      sreg       <= '0;
      byte_idx   <= '0;
      cnt        <= '0;
      fetch_ph   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            tbl_line <= line_sel;
            busy     <= 1'b1;
            err      <= 1'b0;
            cnt      <= '0;
            state    <= TBL;
          end
        end
        TBL: state <= RANGE;
        RANGE: begin
          end_q <= tbl_end;
          if (tbl_start > tbl_end) begin
            // Reversed range: keep framing by sending a full pad line.
            err        <= 1'b1;
            char_data  <= PAD_CHAR;
            char_valid <= 1'b1;
            char_last  <= (LAST_IDX == 8'd0);
            state      <= PAD;
          end else begin
            mem_addr <= tbl_start;
            fetch_ph <= 1'b0;
            state    <= FETCH;
          end
        end
        FETCH: begin
          if (!fetch_ph) begin
            fetch_ph <= 1'b1;
          end else begin
            char_data  <= mem_data[DW-1 -: 8];
            sreg       <= mem_data << 8;
            byte_idx   <= '0;
            char_valid <= 1'b1;
            char_last  <= (cnt == LAST_IDX);
            state      <= EMIT;
          end
        end
        EMIT: begin
          if (xfer) begin
            cnt <= cnt_nxt;
            if (char_last) begin
              // Line complete; any bytes left in sreg are dropped.
              busy       <= 1'b0;
              char_valid <= 1'b0;
              char_last  <= 1'b0;
              state      <= IDLE;
            end else if (byte_idx == LAST_BYTE) begin
              if (mem_addr == end_q) begin
                char_data <= PAD_CHAR;
                char_last <= (cnt_nxt == LAST_IDX);
                state     <= PAD;
              end else begin
                char_valid <= 1'b0;
                mem_addr   <= mem_addr + ADDR_W'(1);
                fetch_ph   <= 1'b0;
                state      <= FETCH;
              end
            end else begin
              char_data <= sreg[DW-1 -: 8];
              sreg      <= sreg << 8;
              byte_idx  <= byte_idx + BI_W'(1);
              char_last <= (cnt_nxt == LAST_IDX);
            end
          end
        end
        PAD: begin
          if (xfer) begin
            cnt <= cnt_nxt;
            if (char_last) begin
              busy       <= 1'b0;
              char_valid <= 1'b0;
              char_last  <= 1'b0;
              state      <= IDLE;
            end else begin
              char_last <= (cnt_nxt == LAST_IDX);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
